ysyx_220053_pipe_adder: RTL

YSYX_220053_PIPE_ADDER -- requirements
Module: ysyx_220053_pipe_adder

---
 rtl/ysyx_220053_alu_pkg.sv | 11 +
 rtl/ysyx_220053_adder_slice.sv | 18 +
 rtl/ysyx_220053_pipe_adder.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_220053_alu_pkg.sv
// Shared ALU constants.
//   XLEN         : native datapath width
//   ADDER_STAGES : default pipeline depth of the pipelined adder
//   WORD_W       : width of an RV64 W-mode operation
package ysyx_220053_alu_pkg;

    localparam int unsigned XLEN         = 64;
    localparam int unsigned ADDER_STAGES = 2;
    localparam int unsigned WORD_W       = 32;

endpackage

// File: rtl/ysyx_220053_adder_slice.sv
// Combinational S-bit ripple slice used by one pipeline stage of the adder.
//   a, b : slice operands (b already inverted for subtraction)
//   cin  : carry into the slice
//   sum  : slice sum
//   cout : carry out of the slice MSB
module ysyx_220053_adder_slice #(
    parameter int unsigned S = 32
) (
    input  logic [S-1:0] a,
    input  logic [S-1:0] b,
    input  logic         cin,
    output logic [S-1:0] sum,
    output logic         cout
);

    assign {cout, sum} = (S+1)'(a) + (S+1)'(b) + (S+1)'(cin);

endmodule

// File: rtl/ysyx_220053_pipe_adder.sv
// Pipelined add/sub unit with valid/ready handshake on both sides.
// Stage k adds slice k of the operands; upper operand slices and the lower
// result slices travel forward with the operation. The last stage applies
// W-mode formatting and registers the final result.
//   clk, rst_n            : clock, asynchronous active-low reset
//   flush                 : drop every in-flight operation at the next edge
//   in_valid/in_ready     : operation handshake
//   in_x, in_y            : operands
//   in_sub                : 1 = x - y, 0 = x + y
//   in_word               : RV64 W-mode (32-bit op, sign-extended result)
//   out_valid/out_ready   : result handshake
//   out_result, out_cout  : result and carry out
//   out_ovf, out_zero     : signed overflow / zero flags, only when
//                           YSYX_220053_ADDER_FLAGS_EN is defined
module ysyx_220053_pipe_adder
    import ysyx_220053_alu_pkg::*;
#(
    parameter int unsigned WIDTH  = XLEN,
    parameter int unsigned STAGES = ADDER_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    input  logic             in_sub,
    input  logic             in_word,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_cout
`ifdef YSYX_220053_ADDER_FLAGS_EN
    ,
    output logic             out_ovf,
    output logic             out_zero
`endif
);

    localparam int unsigned S    = WIDTH / STAGES;
    localparam int unsigned LAST = STAGES - 1;
    localparam int unsigned RAW  = (STAGES > 1) ? STAGES - 1 : 1;

    logic [STAGES-1:0]             valid_q, valid_d;
    logic [STAGES-1:0]             adv, load;
    logic [STAGES:0]               free;

    logic [STAGES-1:0][WIDTH-1:0]  src_x, src_y, src_s, sum_c;
    logic [STAGES-1:0]             src_c, src_w;
    logic [STAGES-1:0][S-1:0]      slc_sum;
    logic [STAGES-1:0]             slc_cout;

    logic [RAW-1:0][WIDTH-1:0]     x_q, y_q, s_q;
    logic [RAW-1:0]                c_q, w_q;

    logic [WIDTH-1:0]              res_d, res_q;
    logic                          cout_d, cout_q;

    // Backpressure chain: a stage is free if empty or emptying this cycle.
    always_comb begin
        free         = '0;
        adv          = '0;
        load         = '0;
        valid_d      = valid_q;
        free[STAGES] = out_ready;
        for (int i = int'(LAST); i >= 0; i--) begin
            adv[i]  = valid_q[i] && free[i+1];
            free[i] = !valid_q[i] || adv[i];
        end
        in_ready = !flush && free[0];
        load[0]  = in_valid && in_ready;
        for (int i = 1; i < int'(STAGES); i++) begin
            load[i] = adv[i-1];
        end
        for (int i = 0; i < int'(STAGES); i++) begin
            if (flush) begin
                valid_d[i] = 1'b0;
            end else if (load[i]) begin
                valid_d[i] = 1'b1;
            end else if (adv[i]) begin
                valid_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Operands feeding each stage: ports for stage 0, previous stage otherwise.
    always_comb begin
        src_x    = '0;
        src_y    = '0;
        src_s    = '0;
        src_c    = '0;
        src_w    = '0;
        src_x[0] = in_x;
        src_y[0] = in_sub ? ~in_y : in_y;
        src_c[0] = in_sub;
        src_w[0] = in_word;
        for (int k = 1; k < int'(STAGES); k++) begin
            src_x[k] = x_q[k-1];
            src_y[k] = y_q[k-1];
            src_s[k] = s_q[k-1];
            src_c[k] = c_q[k-1];
            src_w[k] = w_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        ysyx_220053_adder_slice #(
            .S (S)
        ) u_slice (
            .a    (src_x[k][k*S +: S]),
            .b    (src_y[k][k*S +: S]),
            .cin  (src_c[k]),
            .sum  (slc_sum[k]),
            .cout (slc_cout[k])
        );
    end

    // Merge each stage's new slice into the partial result it carries.
    always_comb begin
        sum_c = src_s;
        for (int k = 0; k < int'(STAGES); k++) begin
            sum_c[k][k*S +: S] = slc_sum[k];
        end
    end

    // Intermediate stage registers; payload only moves on load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0;
            y_q <= '0;
            s_q <= '0;
            c_q <= '0;
            w_q <= '0;
        end else begin
            for (int k = 0; k < int'(LAST); k++) begin
                if (load[k]) begin
                    x_q[k] <= src_x[k];
                    y_q[k] <= src_y[k];
                    s_q[k] <= sum_c[k];
                    c_q[k] <= slc_cout[k];
                    w_q[k] <= src_w[k];
                end
            end
        end
    end

    // Final formatting. In W-mode the carry out of bit 31 is recovered from
    // bit 32 of the full sum: sum[32] = x[32] ^ y[32] ^ carry_into_32.
    if (WIDTH > WORD_W) begin : g_word
        always_comb begin
            res_d  = sum_c[LAST];
            cout_d = slc_cout[LAST];
            if (src_w[LAST]) begin
                res_d  = {{(WIDTH-WORD_W){sum_c[LAST][WORD_W-1]}}, sum_c[LAST][WORD_W-1:0]};
                cout_d = sum_c[LAST][WORD_W] ^ src_x[LAST][WORD_W] ^ src_y[LAST][WORD_W];
            end
        end
    end else begin : g_noword
        assign res_d  = sum_c[LAST];
        assign cout_d = slc_cout[LAST];
    end

    // Last-stage operands are only partly consumed (sign bits, W-mode carry).
    logic unused_bits;
    assign unused_bits = ^{src_x[LAST], src_y[LAST], src_s[LAST], src_w[LAST]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q  <= '0;
            cout_q <= 1'b0;
        end else if (load[LAST]) begin
            res_q  <= res_d;
            cout_q <= cout_d;
        end
    end

    assign out_valid  = valid_q[LAST];
    assign out_result = res_q;
    assign out_cout   = cout_q;

`ifdef YSYX_220053_ADDER_FLAGS_EN
    localparam int unsigned SGN_W = (WIDTH > WORD_W) ? WORD_W - 1 : WIDTH - 1;

    logic sgn_x, sgn_y, ovf_d, zero_d, ovf_q, zero_q;

    // Overflow: operands of equal sign produce a result of the other sign.
    // A W-mode result is sign-extended, so its MSB already equals bit 31.
    always_comb begin
        sgn_x  = src_w[LAST] ? src_x[LAST][SGN_W] : src_x[LAST][WIDTH-1];
        sgn_y  = src_w[LAST] ? src_y[LAST][SGN_W] : src_y[LAST][WIDTH-1];
        ovf_d  = (sgn_x == sgn_y) && (res_d[WIDTH-1] != sgn_x);
        zero_d = (res_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (load[LAST]) begin
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    assign out_ovf  = ovf_q;
    assign out_zero = zero_q;
`endif

endmodule
